// File: rtl/led_matrix_scan.sv
// Row-scanning driver for an 8x8 LED matrix with a double-buffered frame image.
// Each row is blanked, then lit; buffer swaps requested mid-scan land on the frame boundary.
module led_matrix_scan #(
    parameter int  DWELL_CYCLES = 1000,
    parameter int  BLANK_CYCLES = 4,
    parameter int  CNT_W        = 16,
    localparam int MATRIX_SIZE  = 8,
    localparam int ROW_W        = $clog2(MATRIX_SIZE)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   scan_en_i,
    input  logic                   wr_valid_i,
    output logic                   wr_ready_o,
    input  logic [ROW_W-1:0]       wr_row_i,
    input  logic [MATRIX_SIZE-1:0] wr_data_i,
    input  logic                   swap_req_i,
    output logic                   swap_pending_o,
    output logic [ROW_W-1:0]       row_sel_o,
    output logic                   decoder_en_o,
    output logic [MATRIX_SIZE-1:0] col_data_o,
    output logic                   frame_done_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_ACTIVE
    } state_e;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(MATRIX_SIZE - 1);

    state_e                 state_q, state_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   front_q, front_d;
    logic                   pending_q, pending_d;
    logic [ROW_W-1:0]       row_sel_q, row_sel_d;
    logic                   dec_en_q, dec_en_d;
    logic [MATRIX_SIZE-1:0] col_q, col_d;
    logic                   frame_done_q, frame_done_d;

    logic [MATRIX_SIZE-1:0] frame_q [2][MATRIX_SIZE];

    logic blank_done;
    logic active_done;
    logic frame_end;
    logic swap_commit;
    logic wr_fire;

    assign blank_done  = (state_q == ST_BLANK) && (cnt_q == BLANK_LAST);
    assign active_done = (state_q == ST_ACTIVE) && (cnt_q == DWELL_LAST);
    assign frame_end   = active_done && (row_q == LAST_ROW);
    // A parked scan has no frame to tear, so a pending swap lands immediately.
    assign swap_commit = pending_q && ((state_q == ST_IDLE) || frame_end);
    assign wr_fire     = wr_valid_i && !pending_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d      = state_q;
        row_d        = row_q;
        cnt_d        = cnt_q;
        row_sel_d    = row_sel_q;
        dec_en_d     = dec_en_q;
        col_d        = col_q;
        frame_done_d = 1'b0;
        front_d      = front_q ^ swap_commit;
        pending_d    = pending_q;

        if (swap_commit) begin
            pending_d = 1'b0;
        end else if (swap_req_i) begin
            pending_d = 1'b1;
        end

        if (!scan_en_i) begin
            state_d   = ST_IDLE;
            row_d     = '0;
            cnt_d     = '0;
            row_sel_d = '0;
            dec_en_d  = 1'b0;
            col_d     = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d   = ST_BLANK;
                    row_d     = '0;
                    cnt_d     = '0;
                    row_sel_d = '0;
                    dec_en_d  = 1'b0;
                    col_d     = '0;
                end
                ST_BLANK: begin
                    if (blank_done) begin
                        state_d  = ST_ACTIVE;
                        cnt_d    = '0;
                        dec_en_d = 1'b1;
                        col_d    = frame_q[front_q][row_q];
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (active_done) begin
                        state_d      = ST_BLANK;
                        row_d        = row_q + ROW_W'(1);
                        row_sel_d    = row_q + ROW_W'(1);
                        cnt_d        = '0;
                        dec_en_d     = 1'b0;
                        col_d        = '0;
                        frame_done_d = frame_end;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            row_q        <= '0;
            cnt_q        <= '0;
            front_q      <= 1'b0;
            pending_q    <= 1'b0;
            row_sel_q    <= '0;
            dec_en_q     <= 1'b0;
            col_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            cnt_q        <= cnt_d;
            front_q      <= front_d;
            pending_q    <= pending_d;
            row_sel_q    <= row_sel_d;
            dec_en_q     <= dec_en_d;
            col_q        <= col_d;
            frame_done_q <= frame_done_d;
        end
    end

    // NOTE: the frame store is reset on purpose: after reset both images must read back as blank.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < MATRIX_SIZE; r++) begin
                    frame_q[b][r] <= '0;
                end
            end
        end else if (wr_fire) begin
            frame_q[~front_q][wr_row_i] <= wr_data_i;
        end
    end

    assign wr_ready_o     = ~pending_q;
    assign swap_pending_o = pending_q;
    assign row_sel_o      = row_sel_q;
    assign decoder_en_o   = dec_en_q;
    assign col_data_o     = col_q;
    assign frame_done_o   = frame_done_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan: expected lit rows are queued when scanning is
// started and checked by a monitor as each row lights up.
module tb_led_matrix_scan;

    localparam int DWELL = 4;
    localparam int BLANK = 2;
    localparam int ROW_P = DWELL + BLANK;

    logic       clk = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       scan_en_i = 1'b0;
    logic       wr_valid_i = 1'b0;
    logic       wr_ready_o;
    logic [2:0] wr_row_i = '0;
    logic [7:0] wr_data_i = '0;
    logic       swap_req_i = 1'b0;
    logic       swap_pending_o;
    logic [2:0] row_sel_o;
    logic       decoder_en_o;
    logic [7:0] col_data_o;
    logic       frame_done_o;

    led_matrix_scan #(
        .DWELL_CYCLES(DWELL),
        .BLANK_CYCLES(BLANK),
        .CNT_W       (16)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n_i),
        .scan_en_i     (scan_en_i),
        .wr_valid_i    (wr_valid_i),
        .wr_ready_o    (wr_ready_o),
        .wr_row_i      (wr_row_i),
        .wr_data_i     (wr_data_i),
        .swap_req_i    (swap_req_i),
        .swap_pending_o(swap_pending_o),
        .row_sel_o     (row_sel_o),
        .decoder_en_o  (decoder_en_o),
        .col_data_o    (col_data_o),
        .frame_done_o  (frame_done_o)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [2:0] row;
        logic [7:0] col;
        int         len;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   in_row  = 1'b0;
    int   run_len = 0;
    int   cyc     = 0;
    int   fd_q[$];
    int   rise_q[$];
    int   checks   = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: one entry per lit row, compared on the rising decoder enable.
    initial begin
        forever begin
            @(negedge clk);
            if (frame_done_o) fd_q.push_back(cyc);
            if (!decoder_en_o) check("col_blank", 32'(col_data_o), 32'd0);
            if (decoder_en_o && !in_row) begin
                rise_q.push_back(cyc);
                check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) cur = exp_q.pop_front();
                in_row  = 1'b1;
                run_len = 1;
                check("row_sel", 32'(row_sel_o), 32'(cur.row));
                check("col_data", 32'(col_data_o), 32'(cur.col));
            end else if (decoder_en_o) begin
                run_len++;
                check("row_hold", 32'(row_sel_o), 32'(cur.row));
                check("col_hold", 32'(col_data_o), 32'(cur.col));
            end else if (in_row) begin
                in_row = 1'b0;
                check("dwell_len", 32'(run_len), 32'(cur.len));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic push_exp(input int r, input logic [7:0] c, input int n);
        exp_q.push_back('{row: 3'(r), col: c, len: n});
    endtask

    task automatic wait_drain(input string tag, input int max_steps);
        bit done = 1'b0;
        for (int i = 0; i < max_steps && !done; i++) begin
            step();
            done = (exp_q.size() == 0) && !in_row;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic wait_active_row(input string tag, input int r);
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            step();
            done = in_row && (cur.row == 3'(r));
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic write_row(input int r, input logic [7:0] d);
        check("wr_ready_idle", 32'(wr_ready_o), 32'd1);
        wr_valid_i = 1'b1;
        wr_row_i   = 3'(r);
        wr_data_i  = d;
        step();
        wr_valid_i = 1'b0;
    endtask

    task automatic pulse_swap_idle(input string tag);
        swap_req_i = 1'b1;
        step();
        swap_req_i = 1'b0;
        check({tag, "_pending"}, 32'(swap_pending_o), 32'd1);
        check({tag, "_ready_low"}, 32'(wr_ready_o), 32'd0);
        step();
        check({tag, "_committed"}, 32'(swap_pending_o), 32'd0);
        check({tag, "_ready_back"}, 32'(wr_ready_o), 32'd1);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] cols [8]);
        for (int r = 0; r < 8; r++) push_exp(r, cols[r], DWELL);
        scan_en_i = 1'b1;
        wait_drain(tag, 120);
        scan_en_i = 1'b0;
        step();
    endtask

    initial begin
        logic [7:0] cols [8];
        int         c_b;
        bit         done;

        // Reset: outputs idle, ready high.
        repeat (3) step();
        check("rst_ready", 32'(wr_ready_o), 32'd1);
        check("rst_pending", 32'(swap_pending_o), 32'd0);
        check("rst_row_sel", 32'(row_sel_o), 32'd0);
        check("rst_dec_en", 32'(decoder_en_o), 32'd0);
        check("rst_col", 32'(col_data_o), 32'd0);
        check("rst_frame_done", 32'(frame_done_o), 32'd0);
        rst_n_i = 1'b1;
        step();
        pulse_swap_idle("rst_swap");
        for (int r = 0; r < 8; r++) cols[r] = 8'h00;
        run_frame("rst_frame_drain", cols);

        // Full frame: walking-one image, two frames, frame_done cadence.
        for (int r = 0; r < 8; r++) write_row(r, 8'(8'h01 << r));
        pulse_swap_idle("ff_swap");
        fd_q.delete();
        rise_q.delete();
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < 8; r++) push_exp(r, 8'(8'h01 << r), DWELL);
        c_b = cyc + 1;
        scan_en_i = 1'b1;
        wait_drain("ff_drain", 250);
        check("ff_first_rise", 32'((rise_q.size() > 0) ? rise_q[0] : -1), 32'(c_b + BLANK));
        check("ff_second_rise", 32'((rise_q.size() > 1) ? rise_q[1] : -1), 32'(c_b + BLANK + ROW_P));
        check("ff_fd_count", 32'(fd_q.size()), 32'd2);
        check("ff_fd_first", 32'((fd_q.size() > 0) ? fd_q[0] : -1), 32'(c_b + 8 * ROW_P));
        check("ff_fd_second", 32'((fd_q.size() > 1) ? fd_q[1] : -1), 32'(c_b + 16 * ROW_P));
        scan_en_i = 1'b0;
        step();

        // Mid-frame swap: request in row 3, blocked write while pending.
        write_row(0, 8'hFF);
        for (int r = 0; r < 8; r++) push_exp(r, 8'(8'h01 << r), DWELL);
        push_exp(0, 8'hFF, DWELL);
        for (int r = 1; r < 8; r++) push_exp(r, 8'h00, DWELL);
        scan_en_i = 1'b1;
        wait_active_row("ms_row3", 3);
        swap_req_i = 1'b1;
        step();
        swap_req_i = 1'b0;
        wr_valid_i = 1'b1;
        wr_row_i   = 3'd1;
        wr_data_i  = 8'h3C;
        check("ms_pending", 32'(swap_pending_o), 32'd1);
        check("ms_ready_low", 32'(wr_ready_o), 32'd0);
        step();
        wr_valid_i = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (swap_pending_o) begin
                check("ms_ready_held_low", 32'(wr_ready_o), 32'd0);
                step();
            end else begin
                done = 1'b1;
            end
        end
        check("ms_commit_seen", 32'(done), 32'd1);
        check("ms_commit_at_frame_end", 32'(frame_done_o), 32'd1);
        check("ms_next_frame_untouched", 32'(exp_q.size()), 32'd8);
        check("ms_ready_back", 32'(wr_ready_o), 32'd1);
        wait_drain("ms_drain", 100);
        scan_en_i = 1'b0;
        step();

        // Disable mid-row 5, then restart from row 0.
        push_exp(0, 8'hFF, DWELL);
        for (int r = 1; r < 5; r++) push_exp(r, 8'h00, DWELL);
        push_exp(5, 8'h00, 1);
        scan_en_i = 1'b1;
        wait_active_row("dis_row5", 5);
        scan_en_i = 1'b0;
        step();
        check("dis_dec_en", 32'(decoder_en_o), 32'd0);
        check("dis_col", 32'(col_data_o), 32'd0);
        check("dis_row_sel", 32'(row_sel_o), 32'd0);
        check("dis_sb_empty", 32'(exp_q.size()), 32'd0);
        step();
        rise_q.delete();
        push_exp(0, 8'hFF, DWELL);
        c_b = cyc + 1;
        scan_en_i = 1'b1;
        step();
        check("reen_blank_dec", 32'(decoder_en_o), 32'd0);
        check("reen_blank_row", 32'(row_sel_o), 32'd0);
        wait_drain("reen_drain", 50);
        check("reen_rise", 32'((rise_q.size() > 0) ? rise_q[0] : -1), 32'(c_b + BLANK));
        scan_en_i = 1'b0;
        step();

        // Simultaneous write and swap request.
        check("sim_ready", 32'(wr_ready_o), 32'd1);
        wr_valid_i = 1'b1;
        wr_row_i   = 3'd2;
        wr_data_i  = 8'hA5;
        swap_req_i = 1'b1;
        step();
        wr_valid_i = 1'b0;
        swap_req_i = 1'b0;
        check("sim_pending", 32'(swap_pending_o), 32'd1);
        step();
        check("sim_committed", 32'(swap_pending_o), 32'd0);
        cols = '{8'h01, 8'h02, 8'hA5, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        run_frame("sim_drain", cols);

        // Reset during ACTIVE with a swap pending.
        fd_q.delete();
        push_exp(0, 8'h01, 2);
        scan_en_i = 1'b1;
        wait_active_row("rm_row0", 0);
        swap_req_i = 1'b1;
        step();
        swap_req_i = 1'b0;
        check("rm_pending_before", 32'(swap_pending_o), 32'd1);
        rst_n_i   = 1'b0;
        scan_en_i = 1'b0;
        step();
        step();
        rst_n_i = 1'b1;
        step();
        check("rm_pending", 32'(swap_pending_o), 32'd0);
        check("rm_ready", 32'(wr_ready_o), 32'd1);
        check("rm_row_sel", 32'(row_sel_o), 32'd0);
        check("rm_dec_en", 32'(decoder_en_o), 32'd0);
        check("rm_col", 32'(col_data_o), 32'd0);
        check("rm_no_frame_done", 32'(fd_q.size()), 32'd0);
        check("rm_sb_empty", 32'(exp_q.size()), 32'd0);
        for (int r = 0; r < 8; r++) cols[r] = 8'h00;
        run_frame("rm_front_clear", cols);
        pulse_swap_idle("rm_swap");
        run_frame("rm_back_clear", cols);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_matrix_scan.md
# led_matrix_scan

Row-scanning driver for the 8x8 LED matrix. It holds a double-buffered 8x8 frame image and cycles the active row 0..7. Each row gets a programmable blanking gap and then a programmable on-time. It drives the 3-bit row select and enable consumed by the downstream 3-to-8 row decoder, plus the 8-bit column data for the active row. It sits between the pattern/control logic, which writes frames, and the row decoder and column drivers.

## Interface
Matrix dimension is fixed at 8 (`MATRIX_SIZE`). The column bus is `MATRIX_SIZE` bits wide.

Parameters:
- DWELL_CYCLES, 1000: clock cycles the selected row is lit; must be >= 1.
- BLANK_CYCLES, 4: clock cycles with the decoder disabled before each row; must be >= 1.
- CNT_W, 16: width of the phase counter; must hold max(DWELL_CYCLES, BLANK_CYCLES).

Ports:
- clk_i  in  1  system clock. Single clock domain; all logic is on the rising edge.
- rst_n_i  in  1  reset, synchronous, active-low.
- scan_en_i  in  1  level-sensitive. 1 = scanning runs; 0 = display blanked and scan parked.
- wr_valid_i  in  1  write request into the back buffer.
- wr_ready_o  out  1  back buffer accepts writes. A write occurs when wr_valid_i & wr_ready_o.
- wr_row_i  in  3  back-buffer row address.
- wr_data_i  in  8  row pattern; bit c = column c, 1 = lit.
- swap_req_i  in  1  single-cycle pulse requesting a front/back buffer exchange.
- swap_pending_o  out  1  a swap has been requested but not yet committed.
- row_sel_o  out  3  row index sent to the row decoder.
- decoder_en_o  out  1  row decoder enable. High only while a row is lit.
- col_data_o  out  8  column data for the lit row. 0 when decoder_en_o = 0.
- frame_done_o  out  1  one-cycle pulse at each frame boundary.

## Operation
- Storage: two 8x8 buffers and a front-pointer bit. The scan reads only the front buffer. Writes target only the back buffer. A swap toggles the pointer, so the old front becomes the back; no copy is made.
- FSM states are IDLE, BLANK and ACTIVE. All outputs are registered.
  - IDLE: decoder_en_o = 0, col_data_o = 0, row_sel_o = 0, counter = 0. When scan_en_i = 1, go to BLANK with row 0.
  - BLANK: decoder_en_o = 0, col_data_o = 0, row_sel_o = current row. After BLANK_CYCLES cycles, go to ACTIVE. On that transition, col_data_o is loaded from front[row].
  - ACTIVE: decoder_en_o = 1. col_data_o holds the value latched on entry. After DWELL_CYCLES cycles, go to BLANK with row+1.
  - Row wrap: after row 7's ACTIVE, row wraps to 0 and the next BLANK begins. In that first BLANK cycle, frame_done_o = 1.
- Disable: scan_en_i = 0 in any state forces IDLE on the next edge. Outputs are blanked and the row returns to 0. swap_pending and buffer contents are retained.
- Swap commit:
  - A swap_req_i pulse sets pending.
  - If the FSM is in IDLE, the swap commits on the next edge.
  - Otherwise it commits on the edge where row 7's ACTIVE ends. Row 0 of the following frame therefore shows the new front buffer.
  - Commit clears pending.
  - swap_req_i while pending is already set is ignored; swaps do not double-toggle.
- Write handshake: wr_ready_o = ~swap_pending_o. The back buffer is frozen from the cycle after a swap request until the commit.
  - A write in the same cycle as swap_req_i is accepted and is included in the swapped frame.
- Reset: clears both buffers to 0, front pointer to 0, pending to 0, the FSM to IDLE, row and counter to 0.
  - Output reset values: wr_ready_o = 1, all other outputs 0.

## Timing
- Row period = BLANK_CYCLES + DWELL_CYCLES. Frame period = 8 x row period.
- From scan_en_i rising while in IDLE, decoder_en_o first rises after 1 + BLANK_CYCLES edges.
- From scan_en_i falling, decoder_en_o drops on the next edge.
- Write-to-display latency: a write is visible only after a committed swap, at the start of the next ACTIVE row-0 phase.
- row_sel_o changes only on BLANK entry. decoder_en_o is never high during a row_sel_o transition, so there is no ghosting.
- A mid-operation reset takes effect on the first edge with rst_n_i = 0. There are no partial writes or partial swaps.

## Test plan
Parameters for all scenarios: DWELL_CYCLES = 4, BLANK_CYCLES = 2.
- **Reset.** Hold rst_n_i = 0 for 3 cycles. Required: all outputs 0 except wr_ready_o = 1. A swap followed by a scan shows col_data_o = 0 on every row.
- **Full frame.**
  - Stimulus: write row r = 8'h01 << r for r = 0..7, pulse swap in IDLE, then set scan_en_i = 1.
  - Required: each row shows 2 blank cycles, then 4 cycles of decoder_en_o = 1 with row_sel_o = r and col_data_o = 1 << r.
  - Required: frame_done_o pulses 48 cycles after the first BLANK, and then every 48 cycles.
- **Mid-frame swap.**
  - Stimulus: pulse swap_req_i during row 3. Attempt a write while the swap is pending. Put 8'hFF in row 0 of the back buffer before the request.
  - Required: swap_pending_o = 1 and wr_ready_o = 0 until the row 7 ACTIVE ends. The attempted write is not accepted. Rows 4..7 keep the old data. The next row 0 shows col_data_o = 8'hFF.
- **Disable mid-row.** Drop scan_en_i during row 5 ACTIVE. Required: the next edge gives decoder_en_o = 0, col_data_o = 0, row_sel_o = 0. Re-enabling restarts at row 0 BLANK.
- **Simultaneous write and swap.** Assert wr_valid_i (row 2, 8'hA5) and swap_req_i in the same cycle. Required: the write is accepted and row 2 shows 8'hA5 after the commit.
- **Reset mid-operation.** Assert rst_n_i = 0 during ACTIVE with a swap pending. Required: pending clears, the FSM is in IDLE, buffers are 0, and no frame_done_o pulse occurs.
